inv_response_monitor: RTL and testbench
=======================================

# inv_response_monitor

Synchronous, self-checking response monitor for the gate-level inverter lab cell. It samples the stimulus driven into a `my_not`-style DUT and the DUT's output, then checks that the output settles to the complement of the input within a bounded number of clock cycles. It counts stimulus edges and failures and reports response latency. It sits on the bench/board side opposite the stimulus generator and turns manual `$monitor` inspection into a pass/fail signal.

## Interface
- `SETTLE`, 2: maximum cycles allowed after a stimulus edge for `y_in` to equal `~a_in`; range 1..2^LAT_W-1.
- `CNT_W`, 8: width of edge and error counters.
- `LAT_W`, 4: width of the latency report.

- `clk`  in  1  single clock; everything samples on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  monitor enable; 0 forces IDLE.
- `clr`  in  1  synchronous clear of counters, `last_lat` and `fail`.
- `a_in`  in  1  stimulus applied to the DUT input.
- `y_in`  in  1  DUT output.
- `edge_cnt`  out  CNT_W  number of `a_in` transitions seen while enabled; saturating.
- `err_cnt`  out  CNT_W  number of detected failures; saturating.
- `last_lat`  out  LAT_W  latency in cycles of the most recent successful response.
- `busy`  out  1  high while in WAIT.
- `err_pulse`  out  1  one-cycle strobe for each failure.
- `fail`  out  1  sticky; set by any failure.

## Operation
- Input stage: `a_q`/`y_q` are registered copies of `a_in`/`y_in`. `a_p` is the previous `a_q`. An edge is `a_q != a_p`. `match` is `y_q === ~a_q`; an X or Z value on `y_q` is a mismatch.
- States: IDLE, CHECK, WAIT. A 2-bit encoding is acceptable.
- IDLE:
  - `busy`=0; no counting.
  - `en`=1 → CHECK next cycle. `a_p` is loaded on entry, so no spurious edge is counted.
- CHECK:
  - Edge with `match`: `edge_cnt`++, `last_lat`←0, stay in CHECK.
  - Edge without `match`: `edge_cnt`++, timer←1, go to WAIT.
  - No edge and no `match`: failure (`err_pulse`, `err_cnt`++, `fail`←1); stay in CHECK. This reports a steady-state mismatch every cycle it persists.
- WAIT:
  - New edge: `edge_cnt`++, timer←1, stay in WAIT. The aborted response is not counted as a failure and not recorded.
  - Else `match`: `last_lat`←timer, go to CHECK.
  - Else timer==SETTLE: failure, go to CHECK.
  - Else timer++.
- `en`=0 in any state → IDLE next cycle. Counters and `fail` hold their values.
- Counters saturate at 2^CNT_W-1 and never wrap. `fail` still sets after saturation.
- Priority: `rst` > `clr` > normal update. In a cycle with `clr`=1, all counters, `last_lat` and `fail` are 0 next cycle, even if an increment was due; the FSM continues normally.

## Timing
- Reset values: state=IDLE, `edge_cnt`=0, `err_cnt`=0, `last_lat`=0, `busy`=0, `err_pulse`=0, `fail`=0, `a_q`=`a_p`=0, `y_q`=0, timer=0.
- The monitor adds one cycle of input registration. An `a_in` change at edge N is detected at edge N+1; counter updates are visible after edge N+1.
- Latency is counted from the detection cycle. A DUT whose output changes in the same cycle as the input reports `last_lat`=0.
- The worst-case failure report comes SETTLE cycles after detection.
- `err_pulse` is high exactly one cycle per failure, registered and aligned with the `err_cnt` update.
- `busy` is registered and equal to (state==WAIT).
- Reset mid-WAIT aborts the wait without reporting a failure.

## Test plan
- Correct inverter, `en`=1, `a_in` toggles at cycles 10, 25, 45 → `edge_cnt`=3, `err_cnt`=0, `fail`=0, `last_lat`=0.
- DUT output delayed by 2 cycles, SETTLE=2 → `last_lat`=2 after each edge, `err_cnt`=0. With a 3-cycle delay → `err_cnt` increments by 1 per edge, one `err_pulse` SETTLE cycles after detection.
- `y_in` stuck at 1 with `a_in`=1 for 5 cycles → `err_cnt`=5, `fail`=1. Then drive `y_in`=Z → mismatch is counted.
- `a_in` toggles twice, 1 cycle apart, with a 2-cycle DUT → `edge_cnt`+2, only the second response is measured, no failure.
- Preload `err_cnt` to 254, then 3 failures → `err_cnt`=255 and holds. `clr` in the same cycle as a failure → counter and `fail` read 0 the next cycle.
- `rst` asserted during WAIT → all outputs at reset values next cycle. After `en` is deasserted and reasserted, no spurious edge is counted.

Source files
------------

// File: rtl/inv_response_monitor.sv
// Response monitor for an inverter cell: registers stimulus and response, checks
// that the response settles to the complement within SETTLE cycles, and keeps stats.
module inv_response_monitor #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned LAT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             a_in,
    input  logic             y_in,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [LAT_W-1:0] last_lat,
    output logic             busy,
    output logic             err_pulse,
    output logic             fail
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic             a_q, a_d, a_p_q, a_p_d, y_q, y_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d, err_cnt_q, err_cnt_d;
    logic [LAT_W-1:0] last_lat_q, last_lat_d, timer_q, timer_d;
    logic             busy_q, busy_d, err_pulse_q, err_pulse_d, fail_q, fail_d;
    logic             edge_seen, match, inc_edge, failure;

    always_comb begin
        a_d         = a_in;
        y_d         = y_in;
        a_p_d       = a_q;
        state_d     = state_q;
        edge_cnt_d  = edge_cnt_q;
        err_cnt_d   = err_cnt_q;
        last_lat_d  = last_lat_q;
        timer_d     = timer_q;
        fail_d      = fail_q;
        err_pulse_d = 1'b0;
        inc_edge    = 1'b0;
        failure     = 1'b0;
        edge_seen   = (a_q != a_p_q);
        // X/Z on the response must count as a mismatch, hence the case equality.
        match       = (y_q === ~a_q);

        if (!en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_CHECK;
                S_CHECK: begin
                    if (edge_seen) begin
                        inc_edge = 1'b1;
                        if (match) begin
                            last_lat_d = '0;
                        end else begin
                            timer_d = LAT_W'(1);
                            state_d = S_WAIT;
                        end
                    end else if (!match) begin
                        failure = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (edge_seen) begin
                        inc_edge = 1'b1;
                        timer_d  = LAT_W'(1);
                    end else if (match) begin
                        last_lat_d = timer_q;
                        state_d    = S_CHECK;
                    end else if (timer_q == LAT_W'(SETTLE)) begin
                        failure = 1'b1;
                        state_d = S_CHECK;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (inc_edge && (edge_cnt_q != '1)) edge_cnt_d = edge_cnt_q + 1'b1;
        if (failure) begin
            err_pulse_d = 1'b1;
            fail_d      = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        end

        if (clr) begin
            edge_cnt_d  = '0;
            err_cnt_d   = '0;
            last_lat_d  = '0;
            fail_d      = 1'b0;
            err_pulse_d = 1'b0;
        end

        busy_d = (state_d == S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= 1'b0;
            a_p_q       <= 1'b0;
            y_q         <= 1'b0;
            edge_cnt_q  <= '0;
            err_cnt_q   <= '0;
            last_lat_q  <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            err_pulse_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            a_p_q       <= a_p_d;
            y_q         <= y_d;
            edge_cnt_q  <= edge_cnt_d;
            err_cnt_q   <= err_cnt_d;
            last_lat_q  <= last_lat_d;
            timer_q     <= timer_d;
            busy_q      <= busy_d;
            err_pulse_q <= err_pulse_d;
            fail_q      <= fail_d;
        end
    end

    assign edge_cnt  = edge_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign last_lat  = last_lat_q;
    assign busy      = busy_q;
    assign err_pulse = err_pulse_q;
    assign fail      = fail_q;

endmodule

// File: tb/tb_inv_response_monitor.sv
// Bench for inv_response_monitor: a delayed-inverter stand-in drives y_in and a
// timestamp-based reference model predicts every output.
module tb_inv_response_monitor;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned LAT_W  = 4;

    logic             clk = 1'b0;
    logic             rst, en, clr, a_in, y_in;
    logic [CNT_W-1:0] edge_cnt, err_cnt;
    logic [LAT_W-1:0] last_lat;
    logic             busy, err_pulse, fail;

    inv_response_monitor #(.SETTLE(SETTLE), .CNT_W(CNT_W), .LAT_W(LAT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .a_in(a_in), .y_in(y_in),
        .edge_cnt(edge_cnt), .err_cnt(err_cnt), .last_lat(last_lat),
        .busy(busy), .err_pulse(err_pulse), .fail(fail)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   dly    = 0;
    logic force_y = 1'b0;
    logic y_force = 1'b0;
    logic hist [0:7];

    // Reference model: pending response tracked as an absolute detection time.
    int   t = 0;
    int   m_pend = -1;
    bit   m_run = 0;
    logic m_aq = 0, m_ap = 0, m_yq = 0;
    int   m_edge = 0, m_err = 0, m_lat = 0;
    bit   m_fail = 0, m_pulse = 0, m_busy = 0;
    int   cmax = (1 << CNT_W) - 1;

    always @(posedge clk) begin
        bit fl, ed, mt;
        t = t + 1;
        if (rst) begin
            m_pend = -1; m_run = 0; m_aq = 0; m_ap = 0; m_yq = 0;
            m_edge = 0; m_err = 0; m_lat = 0; m_fail = 0; m_pulse = 0; m_busy = 0;
        end else begin
            fl = 0;
            ed = (m_aq != m_ap);
            mt = (m_yq === ~m_aq);
            if (m_run && en) begin
                if (m_pend < 0) begin
                    if (ed) begin
                        m_edge = (m_edge < cmax) ? m_edge + 1 : cmax;
                        if (mt) m_lat = 0; else m_pend = t;
                    end else if (!mt) fl = 1;
                end else begin
                    if (ed) begin
                        m_edge = (m_edge < cmax) ? m_edge + 1 : cmax;
                        m_pend = t;
                    end else if (mt) begin
                        m_lat = t - m_pend; m_pend = -1;
                    end else if (t - m_pend == SETTLE) begin
                        fl = 1; m_pend = -1;
                    end
                end
            end
            if (!en) m_pend = -1;
            m_run = en;
            if (fl) begin m_err = (m_err < cmax) ? m_err + 1 : cmax; m_fail = 1; end
            m_pulse = fl;
            if (clr) begin m_edge = 0; m_err = 0; m_lat = 0; m_fail = 0; m_pulse = 0; end
            m_ap = m_aq; m_aq = a_in; m_yq = y_in;
            m_busy = (m_pend >= 0);
        end
    end

    // One clock: apply stimulus, let the delayed inverter respond, step past the edge.
    task automatic cyc(input logic a);
        a_in = a;
        y_in = force_y ? y_force : (dly == 0 ? ~a : ~hist[dly-1]);
        @(posedge clk);
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = a;
        #1;
    endtask

    task automatic do_clr(input logic a);
        clr = 1'b1; cyc(a); clr = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0;
        cyc(1'b0); cyc(1'b0);
        n_chk++; if (edge_cnt !== 0)  begin n_fail++; $display("FAIL reset_edge: got %0d want 0", edge_cnt); end
        n_chk++; if (err_cnt !== 0)   begin n_fail++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
        n_chk++; if (last_lat !== 0)  begin n_fail++; $display("FAIL reset_lat: got %0d want 0", last_lat); end
        n_chk++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b want 0", err_pulse); end
        n_chk++; if (fail !== 1'b0)   begin n_fail++; $display("FAIL reset_fail: got %b want 0", fail); end
        rst = 1'b0;
    endtask

    task automatic test_correct;
        logic a = 1'b0;
        dly = 0; en = 1'b1;
        repeat (4) cyc(a);
        do_clr(a);
        for (int c = 0; c < 50; c++) begin
            if (c == 10 || c == 25 || c == 45) a = ~a;
            cyc(a);
        end
        repeat (3) cyc(a);
        n_chk++; if (edge_cnt !== 3) begin n_fail++; $display("FAIL correct_edge: got %0d want 3", edge_cnt); end
        n_chk++; if (err_cnt !== 0)  begin n_fail++; $display("FAIL correct_err: got %0d want 0", err_cnt); end
        n_chk++; if (fail !== 1'b0)  begin n_fail++; $display("FAIL correct_fail: got %b want 0", fail); end
        n_chk++; if (last_lat !== 0) begin n_fail++; $display("FAIL correct_lat: got %0d want 0", last_lat); end
    endtask

    task automatic test_delay;
        logic a = a_in;
        dly = 2;
        do_clr(a);
        for (int e = 0; e < 3; e++) begin
            a = ~a;
            for (int j = 0; j < 8; j++) cyc(a);
            n_chk++; if (last_lat !== 2) begin n_fail++; $display("FAIL delay2_lat: got %0d want 2", last_lat); end
            n_chk++; if (err_cnt !== 0)  begin n_fail++; $display("FAIL delay2_err: got %0d want 0", err_cnt); end
        end
        n_chk++; if (edge_cnt !== 3) begin n_fail++; $display("FAIL delay2_edge: got %0d want 3", edge_cnt); end
        dly = 3;
        do_clr(a);
        for (int e = 0; e < 3; e++) begin
            a = ~a;
            for (int j = 0; j < 10; j++) begin
                cyc(a);
                n_chk++;
                if (err_pulse !== (j == 1 + SETTLE)) begin
                    n_fail++; $display("FAIL delay3_pulse: j=%0d got %b want %b", j, err_pulse, (j == 1 + SETTLE));
                end
            end
            n_chk++; if (err_cnt !== e + 1) begin n_fail++; $display("FAIL delay3_err: got %0d want %0d", err_cnt, e + 1); end
        end
        n_chk++; if (fail !== 1'b1) begin n_fail++; $display("FAIL delay3_fail: got %b want 1", fail); end
    endtask

    task automatic test_stuck;
        int base;
        dly = 0;
        repeat (4) cyc(1'b1);
        do_clr(1'b1);
        force_y = 1'b1; y_force = 1'b1;
        repeat (5) cyc(1'b1);
        force_y = 1'b0;
        repeat (4) cyc(1'b1);
        n_chk++; if (err_cnt !== 5) begin n_fail++; $display("FAIL stuck_err: got %0d want 5", err_cnt); end
        n_chk++; if (fail !== 1'b1) begin n_fail++; $display("FAIL stuck_fail: got %b want 1", fail); end
        repeat (4) cyc(1'b0);
        base = int'(err_cnt);
        force_y = 1'b1; y_force = 1'bz;
        repeat (2) cyc(1'b0);
        force_y = 1'b0;
        repeat (4) cyc(1'b0);
        n_chk++; if (err_cnt !== base + 2) begin n_fail++; $display("FAIL stuck_z: got %0d want %0d", err_cnt, base + 2); end
    endtask

    task automatic test_back_to_back;
        dly = 2;
        repeat (4) cyc(1'b0);
        do_clr(1'b0);
        cyc(1'b1); cyc(1'b0);
        repeat (8) cyc(1'b0);
        n_chk++; if (edge_cnt !== 2) begin n_fail++; $display("FAIL b2b_edge: got %0d want 2", edge_cnt); end
        n_chk++; if (last_lat !== 2) begin n_fail++; $display("FAIL b2b_lat: got %0d want 2", last_lat); end
        n_chk++; if (err_cnt !== 0)  begin n_fail++; $display("FAIL b2b_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_saturate;
        dly = 0;
        repeat (4) cyc(1'b0);
        do_clr(1'b0);
        force_y = 1'b1; y_force = 1'b0;
        repeat (254) cyc(1'b0);
        force_y = 1'b0; repeat (2) cyc(1'b0);
        n_chk++; if (err_cnt !== 254) begin n_fail++; $display("FAIL sat_254: got %0d want 254", err_cnt); end
        force_y = 1'b1; repeat (3) cyc(1'b0);
        force_y = 1'b0; repeat (2) cyc(1'b0);
        n_chk++; if (err_cnt !== 255) begin n_fail++; $display("FAIL sat_255: got %0d want 255", err_cnt); end
        force_y = 1'b1; repeat (5) cyc(1'b0);
        force_y = 1'b0; repeat (2) cyc(1'b0);
        n_chk++; if (err_cnt !== 255) begin n_fail++; $display("FAIL sat_hold: got %0d want 255", err_cnt); end
        n_chk++; if (fail !== 1'b1)   begin n_fail++; $display("FAIL sat_fail: got %b want 1", fail); end
        force_y = 1'b1; repeat (3) cyc(1'b0);
        do_clr(1'b0);
        n_chk++; if (err_cnt !== 0) begin n_fail++; $display("FAIL clr_err: got %0d want 0", err_cnt); end
        n_chk++; if (fail !== 1'b0) begin n_fail++; $display("FAIL clr_fail: got %b want 0", fail); end
        force_y = 1'b0; cyc(1'b0);
        n_chk++; if (err_cnt !== 1) begin n_fail++; $display("FAIL clr_after: got %0d want 1", err_cnt); end
        repeat (2) cyc(1'b0);
    endtask

    task automatic test_rst_wait;
        dly = 3;
        cyc(1'b1); cyc(1'b1);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_pre: got %b want 1", busy); end
        rst = 1'b1; cyc(1'b1); rst = 1'b0;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_chk++; if (edge_cnt !== 0 || err_cnt !== 0 || last_lat !== 0 || err_pulse !== 1'b0 || fail !== 1'b0) begin
            n_fail++; $display("FAIL rst_outs: got edge=%0d err=%0d lat=%0d pulse=%b fail=%b want all 0",
                               edge_cnt, err_cnt, last_lat, err_pulse, fail);
        end
        dly = 0; en = 1'b0;
        cyc(1'b0); cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b1); cyc(1'b1);
        en = 1'b1;
        repeat (6) cyc(1'b1);
        n_chk++; if (edge_cnt !== 0) begin n_fail++; $display("FAIL reenable_edge: got %0d want 0", edge_cnt); end
        n_chk++; if (err_cnt !== 0)  begin n_fail++; $display("FAIL reenable_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_random;
        logic a = a_in;
        for (int c = 0; c < 600; c++) begin
            en  = ($urandom_range(0, 15) != 0);
            clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 39) == 0) dly = $urandom_range(0, 3);
            force_y = ($urandom_range(0, 19) == 0);
            y_force = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a = ~a;
            cyc(a);
            n_chk++;
            if (edge_cnt !== CNT_W'(m_edge) || err_cnt !== CNT_W'(m_err) || last_lat !== LAT_W'(m_lat) ||
                busy !== m_busy || err_pulse !== m_pulse || fail !== m_fail) begin
                n_fail++;
                $display("FAIL random c=%0d: got edge=%0d err=%0d lat=%0d busy=%b pulse=%b fail=%b want edge=%0d err=%0d lat=%0d busy=%b pulse=%b fail=%b",
                         c, edge_cnt, err_cnt, last_lat, busy, err_pulse, fail,
                         m_edge, m_err, m_lat, m_busy, m_pulse, m_fail);
            end
        end
        clr = 1'b0; force_y = 1'b0; en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; a_in = 1'b0; y_in = 1'b1;
        for (int i = 0; i < 8; i++) hist[i] = 1'b0;
        test_reset;
        test_correct;
        test_delay;
        test_stuck;
        test_back_to_back;
        test_saturate;
        test_rst_wait;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
